dsd_pcm_modulator: RTL

- Stereo PCM-to-DSD encoder: the transmit-side counterpart of the DSD128 tap-ROM FIR decimator.
- Accepts signed PCM samples over a valid/ready handshake and holds each one for OSR DSD bit periods.
- Runs a 2nd-order sigma-delta loop per channel and emits 1-bit DSD streams with a bit strobe.
- Also emits 10-bit history buses whose bit ordering matches the decimator's x0..x9 / y0..y9 sign inputs, so the two blocks can be looped back in test.

---
 rtl/dsd_pcm_modulator.sv | 108 ++++++++++
 1 files changed

// File: rtl/dsd_pcm_modulator.sv
// dsd_pcm_modulator: stereo PCM-to-DSD encoder, 2nd-order sigma-delta per channel
// with a shared divider/bit timing chain and decimator-compatible history buses.
module dsd_sdm2 #(
  parameter int PCM_W = 24,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic signed [PCM_W-1:0] x,
  output logic                    q,
  output logic [9:0]              hist
);
  localparam int EW = ACC_W + 2;
  localparam logic signed [EW-1:0] FS   = {{(EW-PCM_W){1'b0}}, 1'b1, {(PCM_W-1){1'b0}}};
  localparam logic signed [EW-1:0] MAXV = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {3'b111, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W-1:0] s1, s2, s1_n, s2_n;
  logic signed [EW-1:0] fb, x_e, sum1, sum2;
  // two guard bits make the pre-clamp sums exact, so clamping replaces wrap
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [EW-1:0] v);
    return v > MAXV ? MAXV[ACC_W-1:0] : v < MINV ? MINV[ACC_W-1:0] : v[ACC_W-1:0];
  endfunction
  always_comb begin
    fb   = q ? FS : -FS;
    x_e  = {{(EW-PCM_W){x[PCM_W-1]}}, x};
    sum1 = {{2{s1[ACC_W-1]}}, s1} + x_e - fb;
    s1_n = sat(sum1);
    sum2 = {{2{s2[ACC_W-1]}}, s2} + {{2{s1_n[ACC_W-1]}}, s1_n} - fb;
    s2_n = sat(sum2);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      q    <= 1'b0;
      hist <= '0;
    end else if (tick) begin
      s1   <= s1_n;
      s2   <= s2_n;
      q    <= ~s2_n[ACC_W-1];
      hist <= {hist[8:0], ~s2_n[ACC_W-1]};
    end
endmodule

module dsd_pcm_modulator #(
  parameter int PCM_W = 24,
  parameter int ACC_W = 32,
  parameter int OSR   = 64,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcm_valid,
  output logic             pcm_ready,
  input  logic [PCM_W-1:0] pcm_left,
  input  logic [PCM_W-1:0] pcm_right,
  output logic             dsd_en,
  output logic             dsd_left,
  output logic             dsd_right,
  output logic [9:0]       dsd_hist_left,
  output logic [9:0]       dsd_hist_right,
  output logic             underrun
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(OSR);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic tick, boundary, accept, pending_full;
  logic signed [PCM_W-1:0] pend_l, pend_r, hold_l, hold_r;
  assign tick      = div_cnt == DW'(DIV - 1);
  assign boundary  = tick && bit_cnt == BW'(OSR - 1);
  assign pcm_ready = !pending_full;
  assign accept    = pcm_valid && pcm_ready;
  // pending refills on accept even at a boundary; hold only takes pending when it was full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      pending_full <= 1'b0;
      pend_l       <= '0;
      pend_r       <= '0;
      hold_l       <= '0;
      hold_r       <= '0;
      dsd_en       <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + DW'(1);
      if (tick) bit_cnt <= boundary ? '0 : bit_cnt + BW'(1);
      pending_full <= (pending_full && !boundary) || accept;
      if (accept) begin
        pend_l <= pcm_left;
        pend_r <= pcm_right;
      end
      if (boundary && pending_full) begin
        hold_l <= pend_l;
        hold_r <= pend_r;
      end
      dsd_en       <= tick;
      underrun     <= boundary && !pending_full;
    end
  dsd_sdm2 #(.PCM_W(PCM_W), .ACC_W(ACC_W)) u_left (
    .clk(clk), .rst(rst), .tick(tick), .x(hold_l), .q(dsd_left), .hist(dsd_hist_left)
  );
  dsd_sdm2 #(.PCM_W(PCM_W), .ACC_W(ACC_W)) u_right (
    .clk(clk), .rst(rst), .tick(tick), .x(hold_r), .q(dsd_right), .hist(dsd_hist_right)
  );
endmodule
